// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32 controllers: opcodes, datapath select codes,
// ALU operations and the multi-cycle FSM state set.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

    // Operation class handed to the ALU decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

endpackage

// File: rtl/multicycle_alu_decoder.sv
// Combinational ALU operation decoder, shared by the single- and multi-cycle
// controllers. Unsupported funct3 values fall back to add and raise illegal_funct.
module multicycle_alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       op5,
    output logic [2:0] alu_control,
    output logic       illegal_funct
);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        alu_control   = ALU_ADD;
        illegal_funct = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: illegal_funct = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32 sequencing controller: registered state, combinational
// next-state and datapath-control decode, memory-ready stalls and opcode traps.
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter bit TRAP_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op_code,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PC_Write,
    output logic       Adr_Src,
    output logic       Mem_write,
    output logic       IR_Write,
    output logic       Reg_write,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALU_SrcA,
    output logic [1:0] ALU_SrcB,
    output logic [2:0] ALU_Control,
    output logic [1:0] Result_Src,
    output logic       illegal,
    output logic       instr_done,
    output logic [3:0] state_dbg
);

    state_t     state, next_state;
    logic [1:0] alu_op;
    logic       use_alu;
    logic [2:0] dec_control;
    logic       illegal_funct;

    multicycle_alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct3        (funct3),
        .funct7        (funct7),
        .op5           (op_code[5]),
        .alu_control   (dec_control),
        .illegal_funct (illegal_funct)
    );

    // NOTE: sequential state uses non-blocking assignments; the comb block below uses blocking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    // rst forces every output low combinationally, so an aborted write drops in the same cycle.
    always_comb begin
        next_state = state;
        PC_Write   = 1'b0;
        Adr_Src    = 1'b0;
        Mem_write  = 1'b0;
        IR_Write   = 1'b0;
        Reg_write  = 1'b0;
        ImmSrc     = 2'b00;
        ALU_SrcA   = 2'b00;
        ALU_SrcB   = 2'b00;
        Result_Src = 2'b00;
        illegal    = 1'b0;
        instr_done = 1'b0;
        alu_op     = ALUOP_ADD;
        use_alu    = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    ALU_SrcA   = SRCA_PC;
                    ALU_SrcB   = SRCB_FOUR;
                    Result_Src = RES_ALU;
                    use_alu    = 1'b1;
                    if (mem_ready) begin
                        IR_Write   = 1'b1;
                        PC_Write   = 1'b1;
                        next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Branch target is precomputed here while the opcode is decoded.
                    ALU_SrcA = SRCA_OLDPC;
                    ALU_SrcB = SRCB_IMM;
                    ImmSrc   = IMM_B;
                    use_alu  = 1'b1;
                    case (op_code)
                        OP_LW, OP_SW: next_state = S_MEMADR;
                        OP_RTYPE:     next_state = S_EXECR;
                        OP_ITYPE:     next_state = S_EXECI;
                        OP_JAL:       next_state = S_JAL;
                        OP_BEQ:       next_state = S_BEQ;
                        default:      next_state = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    ALU_SrcA   = SRCA_RD1;
                    ALU_SrcB   = SRCB_IMM;
                    ImmSrc     = op_code[5] ? IMM_S : IMM_I;
                    use_alu    = 1'b1;
                    next_state = op_code[5] ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    Adr_Src = 1'b1;
                    if (mem_ready) next_state = S_MEMWB;
                end
                S_MEMWB: begin
                    Result_Src = RES_MEM;
                    Reg_write  = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_MEMWRITE: begin
                    Adr_Src   = 1'b1;
                    Mem_write = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        next_state = S_FETCH;
                    end
                end
                S_EXECR, S_EXECI: begin
                    ALU_SrcA   = SRCA_RD1;
                    ALU_SrcB   = (state == S_EXECI) ? SRCB_IMM : SRCB_RD2;
                    ImmSrc     = IMM_I;
                    alu_op     = ALUOP_FUNCT;
                    use_alu    = 1'b1;
                    illegal    = illegal_funct;
                    next_state = S_ALUWB;
                end
                S_ALUWB: begin
                    Result_Src = RES_ALUOUT;
                    Reg_write  = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_JAL: begin
                    ALU_SrcA   = SRCA_OLDPC;
                    ALU_SrcB   = SRCB_FOUR;
                    ImmSrc     = IMM_J;
                    Result_Src = RES_ALUOUT;
                    PC_Write   = 1'b1;
                    use_alu    = 1'b1;
                    next_state = S_ALUWB;
                end
                S_BEQ: begin
                    ALU_SrcA   = SRCA_RD1;
                    ALU_SrcB   = SRCB_RD2;
                    Result_Src = RES_ALUOUT;
                    alu_op     = ALUOP_SUB;
                    use_alu    = 1'b1;
                    PC_Write   = zero;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_TRAP: begin
                    illegal    = 1'b1;
                    next_state = TRAP_HALT ? S_TRAP : S_FETCH;
                end
                default: next_state = S_FETCH;
            endcase
        end
    end

    assign ALU_Control = use_alu ? dec_control : 3'b000;
    assign state_dbg   = rst ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm; a halting and a non-halting
// instance share all inputs.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op_code = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       h_pcw, h_adr, h_mw, h_irw, h_rw, h_ill, h_done;
    logic [1:0] h_imm, h_sa, h_sb, h_rs;
    logic [2:0] h_alu;
    logic [3:0] h_st;
    logic       r_pcw, r_adr, r_mw, r_irw, r_rw, r_ill, r_done;
    logic [1:0] r_imm, r_sa, r_sb, r_rs;
    logic [2:0] r_alu;
    logic [3:0] r_st;

    logic [21:0] h_outs, r_outs;
    assign h_outs = {h_pcw, h_adr, h_mw, h_irw, h_rw, h_imm, h_sa, h_sb, h_alu, h_rs, h_ill, h_done, h_st};
    assign r_outs = {r_pcw, r_adr, r_mw, r_irw, r_rw, r_imm, r_sa, r_sb, r_alu, r_rs, r_ill, r_done, r_st};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.TRAP_HALT(1'b1)) dut_halt (
        .clk(clk), .rst(rst), .op_code(op_code), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready),
        .PC_Write(h_pcw), .Adr_Src(h_adr), .Mem_write(h_mw), .IR_Write(h_irw),
        .Reg_write(h_rw), .ImmSrc(h_imm), .ALU_SrcA(h_sa), .ALU_SrcB(h_sb),
        .ALU_Control(h_alu), .Result_Src(h_rs), .illegal(h_ill),
        .instr_done(h_done), .state_dbg(h_st)
    );

    multicycle_control_fsm #(.TRAP_HALT(1'b0)) dut_ret (
        .clk(clk), .rst(rst), .op_code(op_code), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready),
        .PC_Write(r_pcw), .Adr_Src(r_adr), .Mem_write(r_mw), .IR_Write(r_irw),
        .Reg_write(r_rw), .ImmSrc(r_imm), .ALU_SrcA(r_sa), .ALU_SrcB(r_sb),
        .ALU_Control(r_alu), .Result_Src(r_rs), .illegal(r_ill),
        .instr_done(r_done), .state_dbg(r_st)
    );

    // Packs expected output values in the same order as h_outs/r_outs.
    function automatic logic [21:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] imm,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input logic [1:0] rs,
                                       input logic ill, input logic done, input logic [3:0] st);
        return {pcw, adr, mw, irw, rw, imm, sa, sb, alu, rs, ill, done, st};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] w);
        op_code = w[6:0];
        funct3  = w[14:12];
        funct7  = w[30];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [21:0] fetch_idle;
        fetch_idle = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 3'b010, 2'b10, 1'b0, 1'b0, 4'd0);
        rst = 1'b1;
        mem_ready = 1'b0;
        set_instr(32'h0);
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (h_outs !== 22'd0) begin
            errors++;
            $display("FAIL reset_outs_halt: got %h expected %h", h_outs, 22'd0);
        end
        checks++;
        if (r_outs !== 22'd0) begin
            errors++;
            $display("FAIL reset_outs_ret: got %h expected %h", r_outs, 22'd0);
        end
        tick();
        rst = 1'b0;
        set_instr(32'h00112223);
        mem_ready = 1'b1;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if ({h_mw, h_st} !== {1'b1, 4'd5}) begin
            errors++;
            $display("FAIL reset_pre_memwrite: got mw=%b st=%0d expected mw=1 st=5", h_mw, h_st);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (h_outs !== 22'd0) begin
            errors++;
            $display("FAIL reset_abort_memwrite: got %h expected %h", h_outs, 22'd0);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (h_outs !== fetch_idle) begin
            errors++;
            $display("FAIL reset_release_fetch: got %h expected %h", h_outs, fetch_idle);
        end
    endtask

    task automatic test_lw();
        logic [21:0] exp_v [5];
        int dones;
        exp_v[0] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 3'b010, 2'b10, 1'b0, 1'b0, 4'd0);
        exp_v[1] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0, 4'd1);
        exp_v[2] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0, 4'd2);
        exp_v[3] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 4'd3);
        exp_v[4] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b1, 4'd4);
        dones = 0;
        do_reset();
        set_instr(32'h00412083);
        mem_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (h_done === 1'b1) dones++;
            checks++;
            if (h_outs !== exp_v[c]) begin
                errors++;
                $display("FAIL lw_cycle%0d: got %h expected %h", c, h_outs, exp_v[c]);
            end
            tick();
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL lw_done_count: got %0d expected 1", dones);
        end
        @(negedge clk);
        checks++;
        if (h_st !== 4'd0) begin
            errors++;
            $display("FAIL lw_return: got state %0d expected 0", h_st);
        end
    endtask

    task automatic test_sw_stall();
        logic [3:0] exp_st [7];
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
        do_reset();
        set_instr(32'h00112223);
        for (int c = 0; c < 7; c++) begin
            mem_ready = (c < 3 || c == 6);
            @(negedge clk);
            checks++;
            if ({h_st, h_mw, h_done} !== {exp_st[c], c >= 3, c == 6}) begin
                errors++;
                $display("FAIL sw_cycle%0d: got st=%0d mw=%b done=%b expected st=%0d mw=%b done=%b",
                         c, h_st, h_mw, h_done, exp_st[c], c >= 3, c == 6);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (h_st !== 4'd0) begin
            errors++;
            $display("FAIL sw_return: got state %0d expected 0", h_st);
        end
    endtask

    task automatic test_alu_ops();
        // instruction, expected {state, ALU_Control, illegal, ALU_SrcB}
        logic [31:0] instr [7];
        logic [9:0]  exp_v [7];
        instr = '{32'h40208033, 32'h0020A033, 32'h40000093, 32'h0020E033,
                  32'h0020F033, 32'h0000E093, 32'h00209033};
        exp_v = '{{4'd6, 3'b011, 1'b0, 2'b00}, {4'd6, 3'b110, 1'b0, 2'b00},
                  {4'd7, 3'b010, 1'b0, 2'b01}, {4'd6, 3'b100, 1'b0, 2'b00},
                  {4'd6, 3'b101, 1'b0, 2'b00}, {4'd7, 3'b100, 1'b0, 2'b01},
                  {4'd6, 3'b010, 1'b1, 2'b00}};
        for (int i = 0; i < 7; i++) begin
            do_reset();
            set_instr(instr[i]);
            mem_ready = 1'b1;
            tick();
            tick();
            @(negedge clk);
            checks++;
            if ({h_st, h_alu, h_ill, h_sb} !== exp_v[i] || h_sa !== 2'b10) begin
                errors++;
                $display("FAIL alu_exec_%h: got st=%0d alu=%b ill=%b sa=%b sb=%b expected %b sa=10",
                         instr[i], h_st, h_alu, h_ill, h_sa, h_sb, exp_v[i]);
            end
            tick();
            @(negedge clk);
            checks++;
            if (h_outs !== mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b1, 4'd8)) begin
                errors++;
                $display("FAIL alu_wb_%h: got %h", instr[i], h_outs);
            end
        end
    endtask

    task automatic test_jal();
        logic [21:0] exp_jal;
        exp_jal = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b01, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0, 4'd9);
        do_reset();
        set_instr(32'h008000EF);
        mem_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (h_outs !== exp_jal) begin
            errors++;
            $display("FAIL jal_state: got %h expected %h", h_outs, exp_jal);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({h_st, h_rw, h_done} !== {4'd8, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL jal_wb: got st=%0d rw=%b done=%b expected 8 1 1", h_st, h_rw, h_done);
        end
    endtask

    task automatic test_beq();
        logic [21:0] exp_beq;
        for (int z = 1; z >= 0; z--) begin
            do_reset();
            set_instr(32'h00208463);
            zero = z[0];
            mem_ready = 1'b1;
            tick();
            tick();
            exp_beq = mk(z[0], 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b011, 2'b00, 1'b0, 1'b1, 4'd10);
            @(negedge clk);
            checks++;
            if (h_outs !== exp_beq) begin
                errors++;
                $display("FAIL beq_zero%0d: got %h expected %h", z, h_outs, exp_beq);
            end
            mem_ready = 1'b0;
            tick();
            @(negedge clk);
            checks++;
            if (h_st !== 4'd0) begin
                errors++;
                $display("FAIL beq_return_zero%0d: got state %0d expected 0", z, h_st);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_fetch_stall();
        do_reset();
        set_instr(32'h40208033);
        for (int c = 0; c < 3; c++) begin
            mem_ready = (c == 2);
            @(negedge clk);
            checks++;
            if ({h_st, h_irw, h_pcw, h_sb} !== {4'd0, c == 2, c == 2, 2'b10}) begin
                errors++;
                $display("FAIL fetch_stall%0d: got st=%0d irw=%b pcw=%b sb=%b", c, h_st, h_irw, h_pcw, h_sb);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (h_st !== 4'd1) begin
            errors++;
            $display("FAIL fetch_advance: got state %0d expected 1", h_st);
        end
    endtask

    task automatic test_trap();
        logic [21:0] exp_trap;
        exp_trap = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0, 4'd11);
        do_reset();
        set_instr(32'h0000007F);
        mem_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (h_outs !== exp_trap || r_outs !== exp_trap) begin
            errors++;
            $display("FAIL trap_entry: got halt=%h ret=%h expected %h", h_outs, r_outs, exp_trap);
        end
        mem_ready = 1'b0;
        tick();
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({h_st, h_ill, r_st, r_ill} !== {4'd11, 1'b1, 4'd0, 1'b0}) begin
                errors++;
                $display("FAIL trap_hold%0d: got halt st=%0d ill=%b ret st=%0d ill=%b",
                         c, h_st, h_ill, r_st, r_ill);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_alu_ops();
        test_jal();
        test_beq();
        test_fetch_stall();
        test_trap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
